// File: rtl/id_stage_sb_pkg.sv
// Shared RV32I decode constants and decode-class helpers for the id_stage_sb slice.
package id_stage_sb_pkg;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    // Opcodes
    localparam logic [6:0] INST_TYPE_I   = 7'b0010011;
    localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
    localparam logic [6:0] INST_TYPE_B   = 7'b1100011;
    localparam logic [6:0] INST_JAL      = 7'b1101111;
    localparam logic [6:0] INST_JALR     = 7'b1100111;
    localparam logic [6:0] INST_LUI      = 7'b0110111;
    localparam logic [6:0] INST_AUIPC    = 7'b0010111;

    // I-type func3
    localparam logic [2:0] INST_ADDI  = 3'b000;
    localparam logic [2:0] INST_SLLI  = 3'b001;
    localparam logic [2:0] INST_SLTI  = 3'b010;
    localparam logic [2:0] INST_SLTIU = 3'b011;
    localparam logic [2:0] INST_XORI  = 3'b100;
    localparam logic [2:0] INST_SRI   = 3'b101;
    localparam logic [2:0] INST_ORI   = 3'b110;
    localparam logic [2:0] INST_ANDI  = 3'b111;

    // R-type func3 that also accept the alternate func7
    localparam logic [2:0] INST_ADD_SUB = 3'b000;
    localparam logic [2:0] INST_SR      = 3'b101;

    // Branch func3 holes
    localparam logic [2:0] INST_B_RSV0 = 3'b010;
    localparam logic [2:0] INST_B_RSV1 = 3'b011;

    localparam logic [2:0] INST_JALR_F3 = 3'b000;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        CLS_BAD,
        CLS_ALU_I,
        CLS_SHIFT_I,
        CLS_ALU_R,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_LUI,
        CLS_AUIPC
    } dec_class_e;

    function automatic dec_class_e classify(input logic [31:0] inst);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        dec_class_e cls;
        op  = inst[6:0];
        f3  = inst[14:12];
        f7  = inst[31:25];
        cls = CLS_BAD;
        case (op)
            INST_TYPE_I: begin
                case (f3)
                    INST_ADDI, INST_SLTI, INST_SLTIU,
                    INST_XORI, INST_ORI, INST_ANDI: cls = CLS_ALU_I;
                    INST_SLLI: cls = (f7 == FUNCT7_BASE) ? CLS_SHIFT_I : CLS_BAD;
                    INST_SRI:  cls = (f7 == FUNCT7_BASE || f7 == FUNCT7_ALT) ? CLS_SHIFT_I : CLS_BAD;
                    default:   cls = CLS_BAD;
                endcase
            end
            INST_TYPE_R_M: begin
                if (f7 == FUNCT7_BASE)
                    cls = CLS_ALU_R;
                else if (f7 == FUNCT7_ALT && (f3 == INST_ADD_SUB || f3 == INST_SR))
                    cls = CLS_ALU_R;
            end
            INST_TYPE_B: cls = (f3 == INST_B_RSV0 || f3 == INST_B_RSV1) ? CLS_BAD : CLS_BRANCH;
            INST_JAL:    cls = CLS_JAL;
            INST_JALR:   cls = (f3 == INST_JALR_F3) ? CLS_JALR : CLS_BAD;
            INST_LUI:    cls = CLS_LUI;
            INST_AUIPC:  cls = CLS_AUIPC;
            default:     cls = CLS_BAD;
        endcase
        return cls;
    endfunction

    function automatic logic class_uses_rs1(input dec_class_e cls);
        return cls inside {CLS_ALU_I, CLS_SHIFT_I, CLS_ALU_R, CLS_BRANCH, CLS_JALR};
    endfunction

    function automatic logic class_uses_rs2(input dec_class_e cls);
        return cls inside {CLS_ALU_R, CLS_BRANCH};
    endfunction

    function automatic logic class_writes_rd(input dec_class_e cls);
        return cls inside {CLS_ALU_I, CLS_SHIFT_I, CLS_ALU_R, CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC};
    endfunction

endpackage

// File: rtl/id_stage_sb_scoreboard.sv
// Per-register outstanding-write counters (x1..x31) with a sticky underflow error flag.
import id_stage_sb_pkg::*;

module id_scoreboard #(
    parameter int MAX_INFLIGHT = 3,
    parameter bit FWD_EN       = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_valid,
    input  logic [4:0] issue_rd,
    input  logic       retire_valid,
    input  logic [4:0] retire_rd,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic [4:0] rd,
    output logic       rs1_busy,
    output logic       rs2_busy,
    output logic       rd_sat,
    output logic       rd_near_sat,
    output logic       err
);

    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_INFLIGHT);

    logic [CW-1:0] cnt [32];

    // A source whose last outstanding write retires this cycle is free when bypass is built in.
    always_comb begin
        rs1_busy    = (rs1 != 5'd0) && (cnt[rs1] != '0)
                      && !(FWD_EN && retire_valid && retire_rd == rs1 && cnt[rs1] == CNT_ONE);
        rs2_busy    = (rs2 != 5'd0) && (cnt[rs2] != '0)
                      && !(FWD_EN && retire_valid && retire_rd == rs2 && cnt[rs2] == CNT_ONE);
        rd_sat      = (rd != 5'd0) && (cnt[rd] == CNT_MAX);
        rd_near_sat = (rd != 5'd0) && (cnt[rd] == CNT_MAX - CNT_ONE);
    end

    // NOTE: the counter array is a state table that must start clean, so it is reset explicitly
    // rather than treated as an uninitialised memory; all updates use <= so every lane sees old values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) cnt[r] <= '0;
            err <= 1'b0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                if (issue_valid && issue_rd == 5'(r) && !(retire_valid && retire_rd == 5'(r)))
                    cnt[r] <= cnt[r] + CNT_ONE;
                else if (retire_valid && retire_rd == 5'(r) && !(issue_valid && issue_rd == 5'(r))
                         && cnt[r] != '0)
                    cnt[r] <= cnt[r] - CNT_ONE;
            end
            if (retire_valid && retire_rd != 5'd0 && cnt[retire_rd] == '0)
                err <= 1'b1;
        end
    end

endmodule

// File: rtl/id_stage_sb.sv
// Registered RV32I decode stage with scoreboard hazard stalls and flush.
// Optional ID_STAGE_FWD_EN: bypass wb_data into a source whose last write retires this cycle.
import id_stage_sb_pkg::*;

module id_stage_sb #(
    parameter int XLEN         = 32,
    parameter int MAX_INFLIGHT = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] inst_i,
    input  logic [XLEN-1:0] inst_addr_i,
    output logic [4:0]      rs1_addr_o,
    output logic [4:0]      rs2_addr_o,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_addr_o,
    output logic [XLEN-1:0] op1_o,
    output logic [XLEN-1:0] op2_o,
    output logic [4:0]      rd_addr_o,
    output logic            reg_wen,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            sb_err
);

`ifdef ID_STAGE_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    dec_class_e      cls;
    logic            use_rs1, use_rs2, wr_rd;
    logic [4:0]      rs1, rs2, rd;
    logic [XLEN-1:0] imm_i, imm_u, rs1_val, rs2_val, d_op1, d_op2;
    logic            rs1_busy, rs2_busy, rd_sat, rd_near_sat;
    logic            held_wr, haz_rs1, haz_rs2, haz_sat, hazard;
    logic            accept, issue;

    assign cls     = classify(inst_i);
    assign use_rs1 = class_uses_rs1(cls);
    assign use_rs2 = class_uses_rs2(cls);
    assign wr_rd   = class_writes_rd(cls);

    assign rs1 = use_rs1 ? inst_i[19:15] : 5'd0;
    assign rs2 = use_rs2 ? inst_i[24:20] : 5'd0;
    assign rd  = wr_rd   ? inst_i[11:7]  : 5'd0;
    assign rs1_addr_o = rs1;
    assign rs2_addr_o = rs2;

    assign imm_i = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
    assign imm_u = {inst_i[31:12], 12'b0};

    assign rs1_val = (FWD_EN && wb_valid && rs1 != 5'd0 && wb_rd == rs1) ? wb_data : rs1_data_i;
    assign rs2_val = (FWD_EN && wb_valid && rs2 != 5'd0 && wb_rd == rs2) ? wb_data : rs2_data_i;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        d_op1 = '0;
        d_op2 = '0;
        case (cls)
            CLS_ALU_I:             begin d_op1 = rs1_val; d_op2 = imm_i; end
            CLS_SHIFT_I:           begin d_op1 = rs1_val; d_op2 = XLEN'(inst_i[24:20]); end
            CLS_ALU_R, CLS_BRANCH: begin d_op1 = rs1_val; d_op2 = rs2_val; end
            CLS_JALR:              begin d_op1 = rs1_val; d_op2 = imm_i; end
            CLS_LUI:               d_op1 = imm_u;
            CLS_AUIPC:             begin d_op1 = imm_u; d_op2 = inst_addr_i; end
            default:               ;
        endcase
    end

    // The held instruction is not yet counted, so it is checked directly against sources and rd.
    assign held_wr = out_valid && reg_wen && rd_addr_o != 5'd0;
    assign haz_rs1 = rs1 != 5'd0 && (rs1_busy || (held_wr && rd_addr_o == rs1));
    assign haz_rs2 = rs2 != 5'd0 && (rs2_busy || (held_wr && rd_addr_o == rs2));
    assign haz_sat = rd != 5'd0 && (rd_sat || (rd_near_sat && held_wr && rd_addr_o == rd));
    assign hazard  = haz_rs1 || haz_rs2 || haz_sat;

    assign in_ready = !hazard && (!out_valid || out_ready) && !flush;
    assign accept   = in_valid && in_ready;
    assign issue    = out_valid && out_ready && !flush;

    id_scoreboard #(
        .MAX_INFLIGHT (MAX_INFLIGHT),
        .FWD_EN       (FWD_EN)
    ) u_sb (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue && reg_wen && rd_addr_o != 5'd0),
        .issue_rd     (rd_addr_o),
        .retire_valid (wb_valid),
        .retire_rd    (wb_rd),
        .rs1          (rs1),
        .rs2          (rs2),
        .rd           (rd),
        .rs1_busy     (rs1_busy),
        .rs2_busy     (rs2_busy),
        .rd_sat       (rd_sat),
        .rd_near_sat  (rd_near_sat),
        .err          (sb_err)
    );

    // Payload loads only on accept, so it stays stable under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            inst_o      <= INST_NOP;
            inst_addr_o <= '0;
            op1_o       <= '0;
            op2_o       <= '0;
            rd_addr_o   <= 5'd0;
            reg_wen     <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            inst_o      <= inst_i;
            inst_addr_o <= inst_addr_i;
            op1_o       <= d_op1;
            op2_o       <= d_op2;
            rd_addr_o   <= rd;
            reg_wen     <= wr_rd;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_stage_sb.sv
// Directed self-checking bench for id_stage_sb; the bench also models the register file.
module tb_id_stage_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] inst_i, inst_addr_i;
    logic [4:0]  rs1_addr_o, rs2_addr_o;
    logic [31:0] rs1_data_i, rs2_data_i;
    logic        out_valid, out_ready;
    logic [31:0] inst_o, inst_addr_o, op1_o, op2_o;
    logic [4:0]  rd_addr_o;
    logic        reg_wen;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush, sb_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] regs [32];

    localparam logic [31:0] I_ADDI_X1_5  = 32'h0050_0093;
    localparam logic [31:0] I_ADD_X2_X1  = 32'h0010_8133;
    localparam logic [31:0] I_AUIPC_X4   = 32'h1234_5217;
    localparam logic [31:0] I_ADDI_X6    = 32'h0010_0313;
    localparam logic [31:0] I_ADDI_X3    = 32'h0010_0193;
    localparam logic [31:0] I_ADDI_X5    = 32'h0090_0293;
    localparam logic [31:0] I_ADD_X8_X5  = 32'h0052_8433;
    localparam logic [31:0] I_BAD        = 32'hFFFF_FFFF;
    localparam logic [31:0] I_JALR_X1    = 32'h0081_00E7;
    localparam logic [31:0] I_SRAI_X9    = 32'h4031_5493;
    localparam logic [31:0] I_LUI_X10    = 32'hABCD_E537;
    localparam logic [31:0] I_ADDI_X11_N = 32'hFFF1_0593;
    localparam logic [31:0] I_BEQ_X2     = 32'h0021_0063;

    always #5 clk = ~clk;

    id_stage_sb dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .inst_i      (inst_i),
        .inst_addr_i (inst_addr_i),
        .rs1_addr_o  (rs1_addr_o),
        .rs2_addr_o  (rs2_addr_o),
        .rs1_data_i  (rs1_data_i),
        .rs2_data_i  (rs2_data_i),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .inst_o      (inst_o),
        .inst_addr_o (inst_addr_o),
        .op1_o       (op1_o),
        .op2_o       (op2_o),
        .rd_addr_o   (rd_addr_o),
        .reg_wen     (reg_wen),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .flush       (flush),
        .sb_err      (sb_err)
    );

    // Write-at-edge, read-combinational register file.
    assign rs1_data_i = regs[rs1_addr_o];
    assign rs2_data_i = regs[rs2_addr_o];
    always @(posedge clk) if (wb_valid && wb_rd != 5'd0) regs[wb_rd] <= wb_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic retire(input logic [4:0] r, input logic [31:0] d);
        wb_valid = 1'b1; wb_rd = r; wb_data = d;
        step();
        wb_valid = 1'b0; wb_rd = 5'd0; wb_data = '0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = '0;
        rst = 1'b1; in_valid = 1'b0; inst_i = '0; inst_addr_i = '0; out_ready = 1'b1;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0; flush = 1'b0;
        step(); step();
        rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_inst", inst_o, 32'h13);
        check("rst_pc", inst_addr_o, 0);
        check("rst_op1", op1_o, 0);
        check("rst_op2", op2_o, 0);
        check("rst_rd", rd_addr_o, 0);
        check("rst_wen", reg_wen, 0);
        check("rst_err", sb_err, 0);

        // RAW: ADDI x1,x0,5 then ADD x2,x1,x1
        in_valid = 1'b1; inst_i = I_ADDI_X1_5; inst_addr_i = 32'h0;
        settle(); check("raw_addi_ready", in_ready, 1);
        step();
        check("raw_addi_valid", out_valid, 1);
        check("raw_addi_op2", op2_o, 5);
        check("raw_addi_rd", rd_addr_o, 1);
        inst_i = I_ADD_X2_X1; inst_addr_i = 32'h4;
        settle();
        check("raw_rs1_addr", rs1_addr_o, 1);
        check("raw_stall_held", in_ready, 0);
        step();
        check("raw_stall_cnt", in_ready, 0);
        wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'd5;
        settle();
`ifdef ID_STAGE_FWD_EN
        check("raw_wb_cycle_ready", in_ready, 1);
        step();
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
`else
        check("raw_wb_cycle_ready", in_ready, 0);
        step();
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        settle(); check("raw_after_wb_ready", in_ready, 1);
        step();
`endif
        check("raw_add_valid", out_valid, 1);
        check("raw_add_op1", op1_o, 5);
        check("raw_add_op2", op2_o, 5);
        check("raw_add_rd", rd_addr_o, 2);
        in_valid = 1'b0;
        step();
        retire(5'd2, 32'h40);
        check("raw_no_err", sb_err, 0);

        // Backpressure with AUIPC at PC 0x100
        out_ready = 1'b0; in_valid = 1'b1; inst_i = I_AUIPC_X4; inst_addr_i = 32'h100;
        step();
        inst_i = I_ADDI_X6; inst_addr_i = 32'h104;
        for (int k = 0; k < 4; k++) begin
            settle();
            check("bp_valid", out_valid, 1);
            check("bp_op1", op1_o, 32'h1234_5000);
            check("bp_op2", op2_o, 32'h100);
            check("bp_ready", in_ready, 0);
            step();
        end
        out_ready = 1'b1;
        settle(); check("bp_release_ready", in_ready, 1);
        step();
        check("bp_next_inst", inst_o, I_ADDI_X6);
        check("bp_next_pc", inst_addr_o, 32'h104);
        in_valid = 1'b0;
        step();
        check("bp_drained", out_valid, 0);
        retire(5'd4, 32'h0);
        retire(5'd6, 32'h1);

        // Saturation: four writes to x3, the fourth waits for a retire
        in_valid = 1'b1; inst_i = I_ADDI_X3; inst_addr_i = 32'h200;
        for (int k = 0; k < 3; k++) begin
            settle(); check("sat_issue_ready", in_ready, 1);
            step();
        end
        for (int k = 0; k < 3; k++) begin
            settle(); check("sat_stall", in_ready, 0);
            step();
        end
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'd1;
        settle(); check("sat_wb_cycle", in_ready, 0);
        step();
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        settle(); check("sat_release", in_ready, 1);
        step();
        in_valid = 1'b0;
        step();
        retire(5'd3, 32'd1);
        retire(5'd3, 32'd1);
        retire(5'd3, 32'd1);
        check("sat_no_err", sb_err, 0);

        // Flush while holding a write to x5
        out_ready = 1'b0; in_valid = 1'b1; inst_i = I_ADDI_X5; inst_addr_i = 32'h300;
        step();
        in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
        settle(); check("flush_ready", in_ready, 0);
        step();
        flush = 1'b0;
        check("flush_valid", out_valid, 0);
        in_valid = 1'b1; inst_i = I_ADD_X8_X5; inst_addr_i = 32'h304;
        settle(); check("flush_x5_free", in_ready, 1);
        step();
        check("flush_add_rd", rd_addr_o, 8);
        in_valid = 1'b0;
        step();

        // sb_err: x0 retire is ignored, x7 underflow is sticky
        retire(5'd0, 32'hDEAD);
        check("err_x0", sb_err, 0);
        retire(5'd8, 32'h0);
        check("err_x8_ok", sb_err, 0);
        retire(5'd7, 32'h0);
        check("err_x7", sb_err, 1);
        step(); step();
        check("err_sticky", sb_err, 1);

        // Unknown opcode then a run of decode classes back-to-back
        in_valid = 1'b1; inst_i = I_BAD; inst_addr_i = 32'h400;
        settle();
        check("bad_rs1_addr", rs1_addr_o, 0);
        check("bad_rs2_addr", rs2_addr_o, 0);
        check("bad_ready", in_ready, 1);
        step();
        check("bad_valid", out_valid, 1);
        check("bad_wen", reg_wen, 0);
        check("bad_op1", op1_o, 0);
        check("bad_op2", op2_o, 0);
        check("bad_rd", rd_addr_o, 0);
        inst_i = I_JALR_X1; inst_addr_i = 32'h404;
        step();
        check("jalr_op1", op1_o, 32'h40);
        check("jalr_op2", op2_o, 8);
        check("jalr_rd", rd_addr_o, 1);
        check("jalr_wen", reg_wen, 1);
        inst_i = I_SRAI_X9; inst_addr_i = 32'h408;
        step();
        check("srai_op1", op1_o, 32'h40);
        check("srai_op2", op2_o, 3);
        inst_i = I_LUI_X10; inst_addr_i = 32'h40C;
        step();
        check("lui_op1", op1_o, 32'hABCD_E000);
        check("lui_op2", op2_o, 0);
        inst_i = I_ADDI_X11_N; inst_addr_i = 32'h410;
        step();
        check("addi_neg_op2", op2_o, 32'hFFFF_FFFF);
        check("addi_neg_rd", rd_addr_o, 11);
        inst_i = I_BEQ_X2; inst_addr_i = 32'h414;
        settle(); check("beq_ready", in_ready, 1);
        step();
        check("beq_wen", reg_wen, 0);
        check("beq_rd", rd_addr_o, 0);
        check("beq_op2", op2_o, 32'h40);
        in_valid = 1'b0;
        step();

        // Reset clears sb_err and all outstanding counts (x1 from JALR)
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst2_err", sb_err, 0);
        check("rst2_valid", out_valid, 0);
        in_valid = 1'b1; inst_i = I_ADD_X2_X1; inst_addr_i = 32'h500;
        settle(); check("rst2_x1_free", in_ready, 1);
        step();
        in_valid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
